// File: rtl/regfile_mul_ctrl_if.sv
// Bus between the shift-add multiplier controller and its sequencer/register file.
// The controller takes the master modport; the other side takes slave.
interface regfile_mul_ctrl_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
);
  logic                 start;
  logic [ADDR_W-1:0]    src_a;
  logic [ADDR_W-1:0]    src_b;
  logic [ADDR_W-1:0]    dst;
  logic [ADDR_W-1:0]    A_addr;
  logic [ADDR_W-1:0]    B_addr;
  logic [WIDTH-1:0]     A_data;
  logic [WIDTH-1:0]     B_data;
  logic [ADDR_W-1:0]    W_addr;
  logic [WIDTH-1:0]     W_data;
  logic                 wr;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    input  start, src_a, src_b, dst, A_data, B_data,
    output A_addr, B_addr, W_addr, W_data, wr, busy, done, product
  );

  modport slave (
    output start, src_a, src_b, dst, A_data, B_data,
    input  A_addr, B_addr, W_addr, W_data, wr, busy, done, product
  );
endinterface

// File: rtl/regfile_mul_ctrl.sv
// Shift-add multiplier that reads two registers and writes the 2*WIDTH product back as two bytes.
// Define REGFILE_MUL_SIGNED_EN for two's-complement operands (sign-magnitude around the core).
module regfile_mul_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input logic                clk,
  input logic                rst,
  regfile_mul_ctrl_if.master bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StCalc, StWrLo, StWrHi, StDone} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [ADDR_W-1:0]    w_addr_q, w_addr_d, dst_q, dst_d;
  logic [WIDTH-1:0]     w_data_q, w_data_d;
  logic                 wr_q, wr_d, busy_q, busy_d, done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d, acc_q, acc_d, res;
  logic [WIDTH-1:0]     mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH:0]       sum;
`ifdef REGFILE_MUL_SIGNED_EN
  logic                 sign_q, sign_d;
`endif

  always_comb begin
    state_d   = state_q;
    a_addr_d  = a_addr_q;
    b_addr_d  = b_addr_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    dst_d     = dst_q;
    product_d = product_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    sum       = '0;
    res       = acc_q;
`ifdef REGFILE_MUL_SIGNED_EN
    sign_d    = sign_q;
    if (sign_q) res = -acc_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_addr_d = bus.src_a;
          b_addr_d = bus.src_b;
          dst_d    = bus.dst;
          state_d  = StLoad;
        end
      end
      StLoad: begin
`ifdef REGFILE_MUL_SIGNED_EN
        mcand_d  = bus.A_data[WIDTH-1] ? -bus.A_data : bus.A_data;
        mplier_d = bus.B_data[WIDTH-1] ? -bus.B_data : bus.B_data;
        sign_d   = bus.A_data[WIDTH-1] ^ bus.B_data[WIDTH-1];
`else
        mcand_d  = bus.A_data;
        mplier_d = bus.B_data;
`endif
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = StCalc;
      end
      StCalc: begin
        // The cycle after the last iteration finalises the result and launches the low-byte write.
        if (cnt_q == CW'(WIDTH)) begin
          acc_d    = res;
          w_addr_d = dst_q;
          w_data_d = res[WIDTH-1:0];
          state_d  = StWrLo;
        end else begin
          sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
          acc_d    = {sum, acc_q[WIDTH-1:1]};
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      StWrLo: begin
        w_addr_d = dst_q + ADDR_W'(1);
        w_data_d = acc_q[2*WIDTH-1:WIDTH];
        state_d  = StWrHi;
      end
      StWrHi: begin
        product_d = acc_q;
        state_d   = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    wr_d   = (state_d == StWrHi) || (state_d == StWrLo);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      dst_q     <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
`ifdef REGFILE_MUL_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      dst_q     <= dst_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
`ifdef REGFILE_MUL_SIGNED_EN
      sign_q    <= sign_d;
`endif
    end
  end

  assign bus.A_addr  = a_addr_q;
  assign bus.B_addr  = b_addr_q;
  assign bus.W_addr  = w_addr_q;
  assign bus.W_data  = w_data_q;
  assign bus.wr      = wr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_regfile_mul_ctrl.sv
// Directed bench for regfile_mul_ctrl with a behavioural 16 x 8 register file.
// Expected products are hand-computed; signed-mode values apply under REGFILE_MUL_SIGNED_EN.
module tb_regfile_mul_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_mul_ctrl_if #(.WIDTH(8), .ADDR_W(4)) bus ();
  regfile_mul_ctrl #(.WIDTH(8), .ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] rf [16];
  logic       pk_en   = 1'b0;
  logic [3:0] pk_addr = '0;
  logic [7:0] pk_data = '0;
  int         nwr     = 0;
  int         checks  = 0;
  int         errors  = 0;

  assign bus.A_data = rf[bus.A_addr];
  assign bus.B_data = rf[bus.B_addr];

  always @(posedge clk) begin
    if (pk_en) begin
      rf[pk_addr] <= pk_data;
    end else if (bus.wr) begin
      rf[bus.W_addr] <= bus.W_data;
      nwr <= nwr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pk_en = 1'b1; pk_addr = a; pk_data = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  // Runs one operation; cycle k is the interval after the k-th edge following acceptance.
  task automatic run_op(input string tag, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] d, input logic [15:0] exp_p, input bit mid_start);
    int         wcyc [2];
    logic [3:0] wad  [2];
    logic [7:0] wdat [2];
    int         nw       = 0;
    int         done_cyc = -1;
    bit         busy_ok  = 1'b1;
    logic [3:0] d1;
    d1 = d + 4'd1;
    for (int i = 0; i < 2; i++) begin wcyc[i] = -1; wad[i] = '0; wdat[i] = '0; end
    @(negedge clk);
    bus.start = 1'b1; bus.src_a = sa; bus.src_b = sb; bus.dst = d;
    @(posedge clk);
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (mid_start && cyc == 5) begin
        bus.start = 1'b1; bus.src_a = sb; bus.src_b = sa; bus.dst = d + 4'd6;
      end
      if (bus.wr) begin
        if (nw < 2) begin wcyc[nw] = cyc; wad[nw] = bus.W_addr; wdat[nw] = bus.W_data; end
        nw++;
      end
      if (bus.done && done_cyc < 0) done_cyc = cyc;
      if (bus.busy !== (cyc <= 12)) busy_ok = 1'b0;
    end
    check({tag, "/nwrites"}, nw, 2);
    check({tag, "/wr_lo_cyc"}, wcyc[0], 10);
    check({tag, "/wr_hi_cyc"}, wcyc[1], 11);
    check({tag, "/wr_lo_addr"}, wad[0], d);
    check({tag, "/wr_hi_addr"}, wad[1], d1);
    check({tag, "/wr_lo_data"}, wdat[0], exp_p[7:0]);
    check({tag, "/wr_hi_data"}, wdat[1], exp_p[15:8]);
    check({tag, "/done_cyc"}, done_cyc, 12);
    check({tag, "/busy_window"}, busy_ok, 1);
    check({tag, "/product"}, bus.product, exp_p);
    check({tag, "/rf_lo"}, rf[d], exp_p[7:0]);
    check({tag, "/rf_hi"}, rf[d1], exp_p[15:8]);
    check({tag, "/a_addr_hold"}, bus.A_addr, sa);
  endtask

  initial begin
    int nwr_snap;
    bus.start = 1'b0; bus.src_a = '0; bus.src_b = '0; bus.dst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/busy", bus.busy, 0);
    check("reset/done", bus.done, 0);
    check("reset/wr", bus.wr, 0);
    check("reset/product", bus.product, 0);
    check("reset/a_addr", bus.A_addr, 0);
    check("reset/w_addr", bus.W_addr, 0);
    check("reset/w_data", bus.W_data, 0);
    rst = 1'b1;

    poke(4'd3, 8'd13); poke(4'd7, 8'd11);
    run_op("basic", 4'd3, 4'd7, 4'd4, 16'h008F, 1'b0);

    poke(4'd0, 8'hFF); poke(4'd1, 8'hFF);
`ifdef REGFILE_MUL_SIGNED_EN
    run_op("wrap", 4'd0, 4'd1, 4'd15, 16'h0001, 1'b0);
`else
    run_op("wrap", 4'd0, 4'd1, 4'd15, 16'hFE01, 1'b0);
`endif

    poke(4'd2, 8'h00); poke(4'd9, 8'hA5); poke(4'd3, 8'h77);
    run_op("overlap", 4'd2, 4'd9, 4'd2, 16'h0000, 1'b0);

    poke(4'd3, 8'd13);
    run_op("ignore_start", 4'd3, 4'd7, 4'd8, 16'h008F, 1'b1);

    // Abort during CALC: reset sampled on the edge of the fourth iteration.
    @(negedge clk);
    bus.start = 1'b1; bus.src_a = 4'd3; bus.src_b = 4'd7; bus.dst = 4'd12;
    @(posedge clk);
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    nwr_snap = nwr;
    rst = 1'b0;
    @(negedge clk);
    check("abort/busy", bus.busy, 0);
    check("abort/wr", bus.wr, 0);
    check("abort/done", bus.done, 0);
    check("abort/product", bus.product, 0);
    check("abort/a_addr", bus.A_addr, 0);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    check("abort/no_writes", nwr, nwr_snap);
    run_op("after_abort", 4'd3, 4'd7, 4'd12, 16'h008F, 1'b0);

    poke(4'd1, 8'hFD); poke(4'd2, 8'h05);
`ifdef REGFILE_MUL_SIGNED_EN
    run_op("mixed_sign", 4'd1, 4'd2, 4'd6, 16'hFFF1, 1'b0);
`else
    run_op("mixed_sign", 4'd1, 4'd2, 4'd6, 16'h04F1, 1'b0);
`endif

    poke(4'd10, 8'h80);
    run_op("min_sq", 4'd10, 4'd10, 4'd11, 16'h4000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mul_ctrl.md
Name: regfile_mul_ctrl

Overview:
Sequential shift-add multiplier controller that acts as master of the 16 x 8-bit register file.
- On a start pulse it reads two source registers over the file's asynchronous read ports and computes the 16-bit product in WIDTH iterations.
- It writes the product back as two bytes: low byte to dst, high byte to dst+1.
- Sits between the instruction/sequencer logic and the register file; drives the file's address, write-data and write-enable inputs.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH; iteration count = WIDTH
ADDR_W, 4, register address width (16 registers)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low
start  input  1  single-cycle request; accepted only in IDLE
src_a  input  ADDR_W  multiplicand register address
src_b  input  ADDR_W  multiplier register address
dst  input  ADDR_W  destination address for low byte; high byte goes to dst+1 mod 16
A_addr  output  ADDR_W  register file read address A
B_addr  output  ADDR_W  register file read address B
A_data  input  WIDTH  register file read data A (combinational from A_addr)
B_data  input  WIDTH  register file read data B
W_addr  output  ADDR_W  register file write address
W_data  output  WIDTH  register file write data
wr  output  1  register file write enable, one cycle per byte
busy  output  1  high from LOAD through DONE inclusive
done  output  1  one-cycle pulse in DONE
product  output  2*WIDTH  last product, held until next accepted start

Behaviour:
- Reset (rst=0 at rising edge):
  - state=IDLE; A_addr=B_addr=W_addr=0; W_data=0; wr=0; busy=0; done=0; product=0.
  - Reset mid-operation aborts immediately; no further writes are issued.
  - A write already registered for that edge is dropped, because wr is cleared by the same edge.
- All outputs are registered.
- States: IDLE -> LOAD -> CALC -> WR_LO -> WR_HI -> DONE -> IDLE.
- IDLE:
  - On start=1, latch src_a, src_b and dst.
  - Drive A_addr=src_a and B_addr=src_b; go to LOAD.
  - start while not in IDLE is ignored, with no queuing.
- LOAD (1 cycle):
  - Capture A_data into the multiplicand register and B_data into the multiplier register.
  - Clear the 2*WIDTH accumulator; iteration counter=0.
  - Operands are now private copies, so dst overlapping a source is harmless.
- CALC (exactly WIDTH cycles, shift-add):
  - Each cycle: if multiplier LSB=1, add multiplicand to the upper WIDTH+1 bits of the accumulator.
  - Then shift the {carry, accumulator} right by 1, and shift the multiplier right by 1.
  - After WIDTH iterations the accumulator holds the unsigned product. No early termination.
- WR_LO: W_addr=dst, W_data=product[WIDTH-1:0], wr=1.
- WR_HI: W_addr=dst+1 (wraps 15->0), W_data=product[2*WIDTH-1:WIDTH], wr=1.
- DONE: wr=0, done=1 for one cycle, product updated; next state IDLE.
- Latency: start accepted at edge 0; the two writes occupy WIDTH+2 and WIDTH+3 cycles after acceptance; done asserts WIDTH+4 cycles after acceptance (12 for WIDTH=8).
- A new start is accepted in the cycle after DONE.
- wr is never high outside WR_LO/WR_HI.
- A_addr and B_addr hold their values outside IDLE.

Optional Feature:
- Macro: REGFILE_MUL_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - LOAD stores the operand magnitudes and the sign XOR of the operands.
  - CALC is unchanged.
  - On entry to WR_LO the accumulator is negated when the sign XOR is 1; a zero result stays zero.
  - -128 * -128 = 0x4000.
  - Latency is unchanged.
- Undefined: unsigned only; no sign logic synthesized.

Test Plan:
- R3=13, R7=11, start src_a=3, src_b=7, dst=4 -> wr pulses at cycles 10 and 11 with W_addr 4 then 5 and W_data 0x8F then 0x00; done at cycle 12; product=0x008F.
- R0=0xFF, R1=0xFF, dst=15 -> R15=0x01, then wrap with W_addr=0 and W_data=0xFE; product=0xFE01.
- R2=0, R9=0xA5, dst=2 (dst equals source) -> R2=0x00, R3=0x00; product=0.
- Second start pulsed at cycle 5 with different addresses -> ignored; exactly two writes with the first operation's values; busy stays continuous.
- rst=0 during CALC iteration 4 -> next cycle state IDLE, busy=0, wr=0, product=0; no writes occur; a subsequent start completes normally.
- R1=0xFD, R2=0x05 -> with REGFILE_MUL_SIGNED_EN product=0xFFF1 (-15); without it product=0x04F1 (1265).
